atm_txn_scheduler: RTL

- Shares one balance database between N_REQ ATM front-ends (terminals).
- Round-robin arbiter grants one requester at a time. A sequencer FSM then performs read, execute, write-back and response for balance, withdraw and deposit transactions.
- Sits between the per-terminal session FSMs (after authentication) and the balance storage, which this block owns.

---
 rtl/atm_txn_scheduler_pkg.sv | 20 ++
 rtl/atm_txn_scheduler_if.sv | 26 ++
 rtl/atm_txn_scheduler_rr_arbiter.sv | 49 ++++
 rtl/atm_txn_scheduler.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/atm_txn_scheduler_pkg.sv
// Shared definitions for the ATM transaction scheduler: opcodes, sequencer
// state encoding and boolean constants.
package atm_txn_scheduler_pkg;

   localparam logic [2:0] OP_BALANCE  = 3'd1;
   localparam logic [2:0] OP_WITHDRAW = 3'd2;
   localparam logic [2:0] OP_DEPOSIT  = 3'd3;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_EXEC  = 3'd2,
      S_WRITE = 3'd3,
      S_RESP  = 3'd4
   } state_t;

endpackage

// File: rtl/atm_txn_scheduler_if.sv
// Terminal-side request/response bundle of the ATM transaction scheduler.
// Slices i of the packed payload buses belong to terminal i.
interface atm_txn_scheduler_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]    req_valid;
   logic [N_REQ-1:0]    req_ready;
   logic [3*N_REQ-1:0]  req_op;
   logic [4*N_REQ-1:0]  req_acc;
   logic [32*N_REQ-1:0] req_amount;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [2:0]          rsp_id;
   logic [31:0]         rsp_balance;
   logic                rsp_success;

   modport master (
      output req_valid, req_op, req_acc, req_amount, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_balance, rsp_success
   );

   modport slave (
      input  req_valid, req_op, req_acc, req_amount, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_balance, rsp_success
   );
endinterface

// File: rtl/atm_txn_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer and
// moves the pointer past the winner whenever the grant is consumed.
module rr_arbiter
   import atm_txn_scheduler_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] grant,
   output logic [2:0]   grant_idx
);

   logic [2:0]   ptr;
   logic [N-1:0] shifted;
   logic         found;
   int           idx;

   // Scan from the pointer, wrapping, so the last winner becomes lowest priority.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = FALSE;
      idx       = 0;
      shifted   = '0;
      for (int k = 0; k < N; k++) begin
         idx     = (int'(ptr) + k) % N;
         shifted = req >> idx;
         if (!found && shifted[0]) begin
            found     = TRUE;
            grant_idx = 3'(idx);
         end
      end
      if (found) begin
         grant = {{(N-1){1'b0}}, 1'b1} << grant_idx;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr <= '0;
      end else if (advance) begin
         ptr <= (int'(grant_idx) == N-1) ? 3'd0 : grant_idx + 3'd1;
      end
   end

endmodule

// File: rtl/atm_txn_scheduler.sv
// Shared balance database serving N_REQ ATM terminals one transaction at a time.
// Define ATM_WITHDRAW_LIMIT_EN to add per-account daily withdrawal caps.
module atm_txn_scheduler
   import atm_txn_scheduler_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int N_ACC    = 10,
   parameter int BAL_STEP = 1000,
   parameter int WD_LIMIT = 5000
) (
   input  logic                 clk,
   input  logic                 rst,
   atm_txn_scheduler_if.slave   bus,
   input  logic                 day_rollover,
   output logic                 busy
);

   state_t            state, state_nxt;
   logic [N_REQ-1:0]  grant;
   logic [2:0]        grant_idx;
   logic              any_req, accept;
   logic [2:0]        op_sel, op_q, id_q;
   logic [3:0]        acc_sel, acc_q;
   logic [31:0]       amt_sel, amt_q, cur_q, new_q, new_d;
   logic              err_q, success_q, success_d, wd_ok;
   logic [32:0]       sum33;
   logic [31:0]       balance [N_ACC];

   assign any_req = |bus.req_valid;
   assign accept  = (state == S_IDLE) && any_req;

   rr_arbiter #(.N(N_REQ)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (bus.req_valid),
      .advance   (accept),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign op_sel  = 3'(bus.req_op     >> (32'(grant_idx) * 32'd3));
   assign acc_sel = 4'(bus.req_acc    >> (32'(grant_idx) * 32'd4));
   assign amt_sel = 32'(bus.req_amount >> (32'(grant_idx) * 32'd32));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (any_req) state_nxt = S_READ;
         S_READ:  state_nxt = S_EXEC;
         S_EXEC:  state_nxt = S_WRITE;
         S_WRITE: state_nxt = S_RESP;
         S_RESP:  if (bus.rsp_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Response fields are zero outside RESP so reset and idle look identical.
   assign bus.req_ready   = (state == S_IDLE) ? grant : '0;
   assign bus.rsp_valid   = (state == S_RESP);
   assign bus.rsp_id      = (state == S_RESP) ? id_q : 3'd0;
   assign bus.rsp_balance = (state == S_RESP) ? new_q : 32'd0;
   assign bus.rsp_success = (state == S_RESP) ? success_q : FALSE;
   assign busy            = (state != S_IDLE);

   always_comb begin
      sum33     = {1'b0, cur_q} + {1'b0, amt_q};
      success_d = FALSE;
      new_d     = cur_q;
      case (op_q)
         OP_BALANCE:  success_d = !err_q;
         OP_WITHDRAW: begin
            if (!err_q && amt_q != 32'd0 && amt_q <= cur_q && wd_ok) begin
               success_d = TRUE;
               new_d     = cur_q - amt_q;
            end
         end
         OP_DEPOSIT: begin
            if (!err_q && amt_q != 32'd0 && !sum33[32]) begin
               success_d = TRUE;
               new_d     = sum33[31:0];
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q      <= '0;
         acc_q     <= '0;
         amt_q     <= '0;
         id_q      <= '0;
         cur_q     <= '0;
         err_q     <= FALSE;
         new_q     <= '0;
         success_q <= FALSE;
         for (int i = 0; i < N_ACC; i++) begin
            balance[i] <= 32'((i + 1) * BAL_STEP);
         end
      end else begin
         case (state)
            S_IDLE: begin
               if (any_req) begin
                  op_q  <= op_sel;
                  acc_q <= acc_sel;
                  amt_q <= amt_sel;
                  id_q  <= grant_idx;
               end
            end
            S_READ: begin
               if (int'(acc_q) >= N_ACC) begin
                  err_q <= TRUE;
                  cur_q <= '0;
               end else begin
                  err_q <= FALSE;
                  cur_q <= balance[acc_q];
               end
            end
            S_EXEC: begin
               new_q     <= new_d;
               success_q <= success_d;
            end
            S_WRITE: begin
               if (success_q && (op_q == OP_WITHDRAW || op_q == OP_DEPOSIT)) begin
                  balance[acc_q] <= new_q;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef ATM_WITHDRAW_LIMIT_EN
   logic [31:0] wd_sum [N_ACC];

   // Widened compare so a huge amount cannot wrap past the cap.
   assign wd_ok = ({1'b0, wd_sum[acc_q]} + {1'b0, amt_q}) <= 33'(WD_LIMIT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N_ACC; i++) wd_sum[i] <= '0;
      end else if (day_rollover) begin
         for (int i = 0; i < N_ACC; i++) wd_sum[i] <= '0;
      end else if (state == S_WRITE && success_q && op_q == OP_WITHDRAW) begin
         wd_sum[acc_q] <= wd_sum[acc_q] + amt_q;
      end
   end
`else
   logic unused_cfg;

   assign wd_ok      = TRUE;
   assign unused_cfg = day_rollover | (WD_LIMIT == 0);
`endif

endmodule
